mppc_test_pulser: RTL and testbench
===================================

// Module: mppc_test_pulser
// PURPOSE
//  Drive side of the MPPC channel: generates calibrated digital test pulses on a
//  pad that is looped into a channel's comparator input. Lets the pulse counter
//  be checked against a known pulse count, width and rate without a sensor.
//  Sits next to the per-channel input logic; the host sets up bursts with a
//  start/busy/done handshake.
// PARAMETERS
//  WIDTH_W   8   bits of pulse_width (high time, clk cycles)
//  GAP_W     16  bits of pulse_gap (low time between pulses, clk cycles)
//  COUNT_W   12  bits of pulse_count / sent; matches the channel counter width
//  JIT_W     4   bits of LFSR jitter added to the gap (only with MPPC_TP_JITTER_EN)
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        asynchronous active-low reset
//  booted       in   1        1 = pads configured; 0 forces IDLE, pulse_out low
//  start        in   1        level-sampled burst request
//  abort        in   1        stop burst immediately
//  pulse_width  in   WIDTH_W  high cycles per pulse; 0 treated as 1
//  pulse_gap    in   GAP_W    low cycles between pulses; 0 treated as 1
//  pulse_count  in   COUNT_W  pulses per burst; 0 = continuous until abort
//  pulse_out    out  1        test pulse to pad, registered, active high
//  busy         out  1        1 while burst in progress
//  done         out  1        one-cycle strobe when a finite burst completes
//  sent         out  COUNT_W  pulses completed in current/last burst
// BEHAVIOUR
//  - Reset: rst_n low (async): state IDLE, pulse_out=0, busy=0, done=0, sent=0,
//    all timers 0. Deassertion takes effect on the next clk edge.
//  - FSM: IDLE -> HIGH -> LOW -> HIGH ... ; all outputs registered.
//  - IDLE: start=1 & booted=1 & abort=0 at edge k -> latch width/gap/count,
//    sent<=0, busy<=1, pulse_out<=1 at edge k (high visible after edge k).
//    Latched values are used for the whole burst; input changes ignored.
//  - HIGH: pulse_out held 1 for exactly max(width,1) cycles. At the end:
//    sent<=sent+1 (wraps mod 2^COUNT_W); if count!=0 and sent+1==count ->
//    IDLE, pulse_out<=0, busy<=0, done<=1 for one cycle; else -> LOW.
//  - LOW: pulse_out held 0 for max(gap,1) cycles (+jitter if enabled), -> HIGH.
//  - Period = max(width,1)+max(gap,1) cycles; no dead cycle between phases.
//  - start while busy: ignored (no restart, no error). start held high after
//    done: a new burst begins the cycle after done (done and busy never both 1).
//  - abort=1 in HIGH/LOW: next edge -> IDLE, pulse_out=0, busy=0, done=0;
//    sent keeps count of completed pulses (truncated pulse not counted).
//  - abort and start both 1 in IDLE: abort wins, no burst.
//  - booted=0 at any time: same as abort; start ignored while booted=0.
//  - Continuous mode (count=0): never asserts done; sent wraps 4095->0 (COUNT_W=12).
//  - Timers sized to WIDTH_W/GAP_W(+1 for jitter); no overflow for max inputs.
// CONFIGURATION
//  MPPC_TP_JITTER_EN defined: 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1),
//    seed 16'hACE1 on reset, steps once per LOW entry; LOW length =
//    max(gap,1)+lfsr[JIT_W-1:0]. Period varies; width and counts unaffected.
//  Not defined: no LFSR logic; LOW length exactly max(gap,1).
// TESTING
//  1. width=3,gap=5,count=4, start 1 cycle -> 4 pulses, each 3 high/5 low,
//     done one cycle at end of 4th high, sent=4, busy low same edge.
//  2. width=0,gap=0,count=2 -> pulses 1 high/1 low, sent=2, done once.
//  3. count=0, width=1,gap=1, run 8200 cycles -> sent wraps past 4095, no done.
//  4. count=10, abort mid 3rd HIGH -> pulse_out 0 next cycle, sent=2, done=0.
//  5. start held high through burst, count=1 -> done, next cycle new burst begins;
//     start with booted=0 or abort=1 -> stays IDLE, outputs 0.
//  6. rst_n low mid-HIGH -> pulse_out/busy/sent 0 asynchronously; with
//     MPPC_TP_JITTER_EN, gap=5 -> every LOW in [5,20] cycles, sequence repeats after reset.

Source files
------------

// File: rtl/mppc_test_pulser.sv
// Test-pulse burst generator for an MPPC channel pad; all outputs registered, first pulse
// high on the start edge. No backpressure: host uses start/busy/done; MPPC_TP_JITTER_EN adds LFSR gap jitter.
module mppc_test_pulser #(
  parameter int WIDTH_W = 8,
  parameter int GAP_W   = 16,
  parameter int COUNT_W = 12,
  parameter int JIT_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               booted,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH_W-1:0] pulse_width,
  input  logic [GAP_W-1:0]   pulse_gap,
  input  logic [COUNT_W-1:0] pulse_count,
  output logic               pulse_out,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] sent
);

`ifdef MPPC_TP_JITTER_EN
  localparam bit JIT_EN = 1'b1;
`else
  localparam bit JIT_EN = 1'b0;
`endif

  // Low timer must hold (gap-1) plus the largest jitter offset without wrapping.
  localparam int JIT_SPAN = JIT_EN ? JIT_W : 0;
  localparam int GAPT_W   = ((GAP_W > JIT_SPAN) ? GAP_W : JIT_SPAN) + (JIT_EN ? 1 : 0);
  localparam int TMR_W    = (WIDTH_W > GAPT_W) ? WIDTH_W : GAPT_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t             state, state_d;
  logic               pulse_d, busy_d, done_d;
  logic [COUNT_W-1:0] sent_d;
  logic [TMR_W-1:0]   timer, timer_d;
  logic [WIDTH_W-1:0] lat_width, lat_width_d;
  logic [GAP_W-1:0]   lat_gap, lat_gap_d;
  logic [COUNT_W-1:0] lat_count, lat_count_d;

  logic               kill;
  logic [COUNT_W-1:0] sent_inc;
  logic               last_pulse;
  logic [TMR_W-1:0]   start_wid_m1;
  logic [TMR_W-1:0]   wid_m1;
  logic [TMR_W-1:0]   low_m1;

  assign kill       = abort | ~booted;
  assign sent_inc   = sent + COUNT_W'(1);
  assign last_pulse = (lat_count != '0) && (sent_inc == lat_count);

  // Zero width/gap behave as one cycle, so the reload value is simply max(x,1)-1.
  assign start_wid_m1 = (pulse_width == '0) ? '0 : TMR_W'(pulse_width) - TMR_W'(1);
  assign wid_m1       = (lat_width == '0)   ? '0 : TMR_W'(lat_width) - TMR_W'(1);

`ifdef MPPC_TP_JITTER_EN
  logic [15:0] lfsr, lfsr_d;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign low_m1  = ((lat_gap == '0) ? '0 : TMR_W'(lat_gap) - TMR_W'(1))
                   + TMR_W'(lfsr[JIT_W-1:0]);

  always_comb begin
    lfsr_d = lfsr;
    if (state == ST_HIGH && !kill && timer == '0 && !last_pulse) begin
      lfsr_d = {lfsr[14:0], lfsr_fb};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= lfsr_d;
    end
  end
`else
  assign low_m1 = (lat_gap == '0) ? '0 : TMR_W'(lat_gap) - TMR_W'(1);
`endif

  always_comb begin
    state_d     = state;
    pulse_d     = pulse_out;
    busy_d      = busy;
    done_d      = 1'b0;
    sent_d      = sent;
    timer_d     = timer;
    lat_width_d = lat_width;
    lat_gap_d   = lat_gap;
    lat_count_d = lat_count;

    case (state)
      ST_IDLE: begin
        pulse_d = 1'b0;
        busy_d  = 1'b0;
        if (start && !kill) begin
          lat_width_d = pulse_width;
          lat_gap_d   = pulse_gap;
          lat_count_d = pulse_count;
          sent_d      = '0;
          busy_d      = 1'b1;
          pulse_d     = 1'b1;
          timer_d     = start_wid_m1;
          state_d     = ST_HIGH;
        end
      end

      ST_HIGH: begin
        if (kill) begin
          state_d = ST_IDLE;
          pulse_d = 1'b0;
          busy_d  = 1'b0;
          timer_d = '0;
        end else if (timer == '0) begin
          sent_d  = sent_inc;
          pulse_d = 1'b0;
          if (last_pulse) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            timer_d = '0;
          end else begin
            state_d = ST_LOW;
            timer_d = low_m1;
          end
        end else begin
          timer_d = timer - TMR_W'(1);
        end
      end

      ST_LOW: begin
        if (kill) begin
          state_d = ST_IDLE;
          pulse_d = 1'b0;
          busy_d  = 1'b0;
          timer_d = '0;
        end else if (timer == '0) begin
          state_d = ST_HIGH;
          pulse_d = 1'b1;
          timer_d = wid_m1;
        end else begin
          timer_d = timer - TMR_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        pulse_d = 1'b0;
        busy_d  = 1'b0;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sent      <= '0;
      timer     <= '0;
      lat_width <= '0;
      lat_gap   <= '0;
      lat_count <= '0;
    end else begin
      state     <= state_d;
      pulse_out <= pulse_d;
      busy      <= busy_d;
      done      <= done_d;
      sent      <= sent_d;
      timer     <= timer_d;
      lat_width <= lat_width_d;
      lat_gap   <= lat_gap_d;
      lat_count <= lat_count_d;
    end
  end

endmodule

// File: tb/tb_mppc_test_pulser.sv
// Bench for mppc_test_pulser: randomized bursts checked against a waveform model
// derived from pulse period arithmetic (pulse i high for t in [i*P, i*P+W)).
module tb_mppc_test_pulser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        booted = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  pulse_width = '0;
  logic [15:0] pulse_gap = '0;
  logic [11:0] pulse_count = '0;
  logic        pulse_out;
  logic        busy;
  logic        done;
  logic [11:0] sent;

  int n_tests = 0;
  int n_fail  = 0;

  mppc_test_pulser dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .booted      (booted),
    .start       (start),
    .abort       (abort),
    .pulse_width (pulse_width),
    .pulse_gap   (pulse_gap),
    .pulse_count (pulse_count),
    .pulse_out   (pulse_out),
    .busy        (busy),
    .done        (done),
    .sent        (sent)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Completed pulses t cycles after the start edge.
  function automatic int sent_at(input int t, input int w_eff, input int period);
    if (t < w_eff) return 0;
    return (t - w_eff) / period + 1;
  endfunction

  task automatic go_idle();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    int k;
    rst_n = 1'b0;
    #12;
    n_tests++;
    if ({pulse_out, busy, done, sent} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %b/%b/%b/%0d want 0/0/0/0", pulse_out, busy, done, sent);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    pulse_width = 8'd4; pulse_gap = 16'd2; pulse_count = 12'd5; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!(sent == 12'd1 && pulse_out) && k < 100) begin
      tick();
      k++;
    end
    n_tests++;
    if (!(sent == 12'd1 && pulse_out === 1'b1 && busy === 1'b1)) begin
      n_fail++;
      $display("FAIL reset_prehigh: got pulse=%b busy=%b sent=%0d want 1/1/1 within 100 cycles", pulse_out, busy, sent);
    end
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({pulse_out, busy, done, sent} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_async: got %b/%b/%b/%0d want 0/0/0/0", pulse_out, busy, done, sent);
    end
    #1 rst_n = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({pulse_out, busy, done, sent} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_release: got %b/%b/%b/%0d want 0/0/0/0", pulse_out, busy, done, sent);
    end
  endtask

  // Runs one burst and checks every cycle against the period model.
  task automatic run_burst(input string name, input int w, input int g, input int n,
                           input int abort_t, input bit use_boot, input int ncyc);
    int w_eff, period, t_end, last, s;
    logic [14:0] exp_v, act_v;
    w_eff  = (w == 0) ? 1 : w;
    period = w_eff + ((g == 0) ? 1 : g);
    t_end  = (n - 1) * period + w_eff;
    last   = (n != 0) ? t_end + 2 : ncyc;
    if (abort_t >= 0) last = abort_t + 2;
    pulse_width = 8'(w); pulse_gap = 16'(g); pulse_count = 12'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    pulse_width = 8'($urandom); pulse_gap = 16'($urandom); pulse_count = 12'($urandom);
    for (int t = 0; t <= last; t++) begin
      if (abort_t >= 0 && t >= abort_t) begin
        s = sent_at(abort_t - 1, w_eff, period);
        exp_v = {1'b0, 1'b0, 1'b0, 12'(s)};
      end else if (n != 0 && t >= t_end) begin
        exp_v = {1'b0, 1'b0, (t == t_end), 12'(n)};
      end else begin
        s = sent_at(t, w_eff, period);
        exp_v = {((t % period) < w_eff), 1'b1, 1'b0, 12'(s)};
      end
      act_v = {pulse_out, busy, done, sent};
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s t=%0d: got pulse=%b busy=%b done=%b sent=%0d want pulse=%b busy=%b done=%b sent=%0d",
                 name, t, act_v[14], act_v[13], act_v[12], act_v[11:0],
                 exp_v[14], exp_v[13], exp_v[12], exp_v[11:0]);
      end
      if (t + 1 == abort_t) begin
        if (use_boot) booted = 1'b0;
        else abort = 1'b1;
      end
      tick();
      abort = 1'b0;
      booted = 1'b1;
    end
    go_idle();
  endtask

  task automatic test_directed_bursts();
    run_burst("burst_3_5_4", 3, 5, 4, -1, 1'b0, 0);
    run_burst("burst_zero_wg", 0, 0, 2, -1, 1'b0, 0);
    run_burst("abort_3rd_high", 3, 5, 10, 17, 1'b0, 0);
    run_burst("unboot_3rd_high", 3, 5, 10, 17, 1'b1, 0);
  endtask

  task automatic test_random_bursts();
    int w, g, n, te, at;
    for (int i = 0; i < 8; i++) begin
      w  = $urandom_range(0, 6);
      g  = $urandom_range(0, 6);
      n  = $urandom_range(1, 5);
      te = (n - 1) * (((w == 0) ? 1 : w) + ((g == 0) ? 1 : g)) + ((w == 0) ? 1 : w);
      at = ((i % 2) == 1 && te >= 2) ? $urandom_range(1, te - 1) : -1;
      run_burst("random_burst", w, g, n, at, 1'($urandom_range(0, 1)), 0);
    end
  endtask

  task automatic test_continuous();
    run_burst("continuous_wrap", 1, 1, 0, -1, 1'b0, 8200);
  endtask

  task automatic test_start_held();
    int w, p;
    logic [14:0] exp_v;
    w = $urandom_range(1, 4);
    p = w + 1;
    pulse_width = 8'(w); pulse_gap = 16'($urandom_range(1, 9)); pulse_count = 12'd1;
    start = 1'b1;
    tick();
    for (int t = 0; t < 3 * p; t++) begin
      if ((t % p) < w) exp_v = {1'b1, 1'b1, 1'b0, 12'd0};
      else exp_v = {1'b0, 1'b0, 1'b1, 12'd1};
      n_tests++;
      if ({pulse_out, busy, done, sent} !== exp_v) begin
        n_fail++;
        $display("FAIL start_held t=%0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", t,
                 pulse_out, busy, done, sent, exp_v[14], exp_v[13], exp_v[12], exp_v[11:0]);
      end
      tick();
    end
    start = 1'b0;
    go_idle();
  endtask

  task automatic test_idle_kill();
    pulse_width = 8'd2; pulse_gap = 16'd2; pulse_count = 12'd3;
    booted = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({pulse_out, busy, done} !== 3'b000) begin
        n_fail++;
        $display("FAIL start_unbooted: got %b/%b/%b want 0/0/0", pulse_out, busy, done);
      end
    end
    booted = 1'b1; abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({pulse_out, busy, done} !== 3'b000) begin
        n_fail++;
        $display("FAIL start_with_abort: got %b/%b/%b want 0/0/0", pulse_out, busy, done);
      end
    end
    start = 1'b0; abort = 1'b0;
    tick();
  endtask

`ifdef MPPC_TP_JITTER_EN
  task automatic measure_lows(output int lows[16], output int got);
    int run;
    got = 0; run = 0;
    pulse_width = 8'd2; pulse_gap = 16'd5; pulse_count = 12'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 1000 && got < 16; c++) begin
      tick();
      if (!pulse_out) run++;
      else if (run != 0) begin
        lows[got] = run;
        got++;
        run = 0;
      end
    end
    go_idle();
  endtask

  task automatic test_jitter();
    int a[16], b[16];
    int ga, gb;
    rst_n = 1'b0; #7 rst_n = 1'b1; tick();
    measure_lows(a, ga);
    rst_n = 1'b0; #7 rst_n = 1'b1; tick();
    measure_lows(b, gb);
    n_tests++;
    if (ga != 16 || gb != 16) begin
      n_fail++;
      $display("FAIL jitter_lows: got %0d/%0d low phases want 16/16 within 1000 cycles", ga, gb);
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_tests++;
        if (a[i] < 5 || a[i] > 20 || a[i] != b[i]) begin
          n_fail++;
          $display("FAIL jitter_low[%0d]: got %0d then %0d want equal and in [5,20]", i, a[i], b[i]);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_idle_kill();
    test_start_held();
`ifdef MPPC_TP_JITTER_EN
    test_jitter();
`else
    test_directed_bursts();
    test_random_bursts();
    test_continuous();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
